// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg (package)
//  Purpose  : Shared widths and control-field bit positions for the ID->EX
//             pipeline slice. Decode packs the control word with these
//             positions and EX unpacks it with the same constants.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default payload widths
    localparam int c_DATA_W          = 16;
    localparam int c_CTRL_W          = 12;

    // Control-word bit positions (bits 10..11 reserved)
    localparam int c_CTRL_WEN        = 0;
    localparam int c_CTRL_ALU_OP_LSB = 1;
    localparam int c_CTRL_ALU_OP_W   = 4;
    localparam int c_CTRL_BRANCH     = 5;
    localparam int c_CTRL_JAL        = 6;
    localparam int c_CTRL_JR         = 7;
    localparam int c_CTRL_LW         = 8;
    localparam int c_CTRL_SW         = 9;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slice_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slice_reg
//  Purpose  : Enable-loaded control+data register with a valid bit. Used as
//             the main entry and, when the skid option is built, the skid
//             entry of pipe_slice.
//  Ports    : clk, rst_n (async, active-low), clr (sync kill of valid/ctrl),
//             load (capture d_*), d_valid/d_ctrl/d_data in,
//             q_valid/q_ctrl/q_data out.
//  Notes    : ctrl is zeroed whenever the entry is invalid so a bubble never
//             carries writes or branches. data is left untouched by clr and
//             by loading an invalid entry.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_slice_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = c_CTRL_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (load) begin
            r_valid <= d_valid;
            r_ctrl  <= d_valid ? d_ctrl : '0;
            if (d_valid) begin
                r_data <= d_data;
            end
        end
    end

    assign q_valid = r_valid;
    assign q_ctrl  = r_ctrl;
    assign q_data  = r_data;

endmodule : pipe_slice_reg
`default_nettype wire

// File: rtl/pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slice
//  Purpose  : ID->EX pipeline register slice with valid/ready handshake,
//             flush and occupancy reporting. All out_* are driven straight
//             from flops.
//  Config   : PIPE_SLICE_SKID_EN defined   -> capacity 2 (main + skid),
//                                             in_ready registered.
//             PIPE_SLICE_SKID_EN undefined -> capacity 1, in_ready =
//                                             !out_valid | out_ready.
//  Ports    : clk, rst_n (async, active-low), flush,
//             in_valid/in_ready/in_ctrl/in_data   (from decode),
//             out_valid/out_ready/out_ctrl/out_data (to execute),
//             occupancy (entries held, 0..2).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int CTRL_W = c_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main register is free to load when empty or being consumed this cycle
    logic              w_main_free;
    logic              w_accept;
    logic              w_main_d_valid;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_d_data;

    assign w_main_free = !out_valid | out_ready;

`ifdef PIPE_SLICE_SKID_EN
    logic              r_in_ready;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_d_valid;
    logic              w_skid_next_valid;

    assign w_accept = in_valid & r_in_ready;

    // A held skid entry always has priority into main; in_ready is low
    // while skid is occupied, so no new entry can compete with it.
    assign w_main_d_valid = w_skid_valid | w_accept;
    assign w_main_d_ctrl  = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_d_data  = w_skid_valid ? w_skid_data : in_data;

    // Skid captures an accept that main cannot take, and empties when its
    // entry moves forward into main.
    assign w_skid_d_valid    = w_accept & !w_main_free;
    assign w_skid_load       = w_skid_d_valid | (w_skid_valid & w_main_free);
    assign w_skid_next_valid = w_skid_valid ? !w_main_free : w_skid_d_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= !w_skid_next_valid;
        end
    end

    pipe_slice_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .load    (w_skid_load),
        .d_valid (w_skid_d_valid),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .q_valid (w_skid_valid),
        .q_ctrl  (w_skid_ctrl),
        .q_data  (w_skid_data)
    );

    assign in_ready  = r_in_ready;
    assign occupancy = {1'b0, out_valid} + {1'b0, w_skid_valid};
`else
    assign w_accept       = in_valid & w_main_free;
    assign w_main_d_valid = w_accept;
    assign w_main_d_ctrl  = in_ctrl;
    assign w_main_d_data  = in_data;

    assign in_ready  = w_main_free;
    assign occupancy = {1'b0, out_valid};
`endif

    pipe_slice_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .load    (w_main_free),
        .d_valid (w_main_d_valid),
        .d_ctrl  (w_main_d_ctrl),
        .d_data  (w_main_d_data),
        .q_valid (out_valid),
        .q_ctrl  (out_ctrl),
        .q_data  (out_data)
    );

endmodule : pipe_slice
`default_nettype wire

// File: tb/tb_pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_slice
//  Purpose  : Self-checking bench for pipe_slice. A capacity-limited FIFO
//             model predicts valid, ctrl, data, occupancy and in_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_slice;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 12;
`ifdef PIPE_SLICE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   last_acc;
    bit   a2;

    always #5 clk = ~clk;

    pipe_slice #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Registered-ready slice can take a new entry while below capacity;
    // the single-entry slice also takes one when the held entry leaves.
    function automatic bit model_ready(input bit ordy);
`ifdef PIPE_SLICE_SKID_EN
        return q.size() < CAP;
`else
        return (q.size() < CAP) || ordy;
`endif
    endfunction

    task automatic check_outputs(input bit ordy);
        bit vld;
        vld = q.size() > 0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, vld});
        chk("out_ctrl", {20'd0, out_ctrl}, vld ? {20'd0, q[0].c} : 32'd0);
        if (vld) chk("out_data", {16'd0, out_data}, {16'd0, q[0].d});
        chk("occupancy", {30'd0, occupancy}, q.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready(ordy)});
    endtask

    // One clock: drive at negedge, check just after, advance model, take edge.
    task automatic step(input bit iv, input bit ordy, input bit fl,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        ent_t e;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
        #1;
        check_outputs(ordy);
        last_acc = iv && model_ready(ordy);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (last_acc) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    function automatic logic [CTRL_W-1:0] rc();
        return CTRL_W'($urandom_range(1, (1 << CTRL_W) - 1));
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #3;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {20'd0, out_ctrl}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 0x0001..0x0008 back-to-back
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, rc(), DATA_W'(i));
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // Stall with A1 held, A2 offered until accepted, then release
        step(1'b1, 1'b0, 1'b0, rc(), 16'h00A1);
        a2 = 1'b0;
        repeat (3) begin
            step(!a2, 1'b0, 1'b0, 12'h0A2, 16'h00A2);
            if (last_acc) a2 = 1'b1;
        end
        repeat (4) begin
            step(!a2, 1'b1, 1'b0, 12'h0A2, 16'h00A2);
            if (last_acc) a2 = 1'b1;
        end
        chk("a2_accepted", {31'd0, a2}, 32'd1);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // Flush while full with a new entry offered
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rc(), DATA_W'(16'h00B1 + i));
        step(1'b1, 1'b0, 1'b1, rc(), 16'h00B0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0), rc(), DATA_W'($urandom));
        end

        // Async reset mid-stall while full
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rc(), DATA_W'(16'h00C0 + i));
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ctrl", {20'd0, out_ctrl}, 32'd0);
        chk("arst_data", {16'd0, out_data}, 32'd0);
        chk("arst_occ", {30'd0, occupancy}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 12'h055, 16'h0055);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipe_slice
`default_nettype wire
